// File: rtl/triangle_loader.sv
// triangle_loader: receives one triangle per 64-bit SPI frame, clamps it into
// a shadow register and commits the shadow to the vertex outputs on frame_start.
//
// state       | meaning
// ------------+----------------------------------------------------------
// S_WAIT_IDLE | after reset; wait for a settled cs_n high before listening
// S_IDLE      | waiting for a cs_n falling edge
// S_SHIFT     | capturing mosi on sclk rising edges until cs_n rises
// S_LOAD      | one cycle; clamped frame written to the shadow
module triangle_loader #(
  parameter int X_MAX = 639,
  parameter int Y_MAX = 479
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  input  logic       frame_start,
  output logic [9:0] v0_x,
  output logic [8:0] v0_y,
  output logic [9:0] v1_x,
  output logic [8:0] v1_y,
  output logic [9:0] v2_x,
  output logic [8:0] v2_y,
  output logic       pending,
  output logic       committed,
  output logic       frame_err
);

  localparam logic [9:0] X_LIM     = 10'(X_MAX);
  localparam logic [8:0] Y_LIM     = 9'(Y_MAX);
  localparam logic [6:0] CNT_FRAME = 7'd64;
  localparam logic [6:0] CNT_SAT   = 7'd65;
  // Only the first 57 bits carry vertex data; the 7 reserved tail bits are
  // never shifted in, so the register ends up holding frame bits [63:7].
  localparam logic [6:0] CNT_DATA  = 7'd57;

  typedef enum logic [1:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_SHIFT,
    S_LOAD
  } state_t;

  state_t      r_state;
  logic [6:0]  r_cnt;
  logic [56:0] r_shift;

  logic r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic r_cs_s1, r_cs_s2, r_cs_d;
  logic r_mosi_s1, r_mosi_s2;

  logic [9:0] r_sh_v0_x, r_sh_v1_x, r_sh_v2_x;
  logic [8:0] r_sh_v0_y, r_sh_v1_y, r_sh_v2_y;

  logic w_sclk_rise;
  logic w_cs_fall;
  logic w_cs_rise;
  logic w_load;

  function automatic logic [9:0] clamp_x(input logic [9:0] v);
    return (v > X_LIM) ? X_LIM : v;
  endfunction

  function automatic logic [8:0] clamp_y(input logic [8:0] v);
    return (v > Y_LIM) ? Y_LIM : v;
  endfunction

  // Two-flop synchronisers plus a delay flop for edge detection. cs_n resets
  // low so WAIT_IDLE only leaves once a real high has crossed the synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_d  <= 1'b0;
      r_cs_s1   <= 1'b0;
      r_cs_s2   <= 1'b0;
      r_cs_d    <= 1'b0;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_sclk_s1 <= spi_sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_cs_s1   <= spi_cs_n;
      r_cs_s2   <= r_cs_s1;
      r_cs_d    <= r_cs_s2;
      r_mosi_s1 <= spi_mosi;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
  assign w_cs_fall   = ~r_cs_s2 & r_cs_d;
  assign w_cs_rise   = r_cs_s2 & ~r_cs_d;
  assign w_load      = (r_state == S_LOAD);

  // Transaction FSM: frame capture, bit counting and length checking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_WAIT_IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (r_state)
        S_WAIT_IDLE: begin
          if (r_cs_s2) begin
            r_state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (w_cs_fall) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_cs_rise) begin
            if (r_cnt == CNT_FRAME) begin
              r_state <= S_LOAD;
            end else begin
              frame_err <= 1'b1;
              r_state   <= S_IDLE;
            end
          end else if (w_sclk_rise) begin
            if (r_cnt < CNT_DATA) begin
              r_shift <= {r_shift[55:0], r_mosi_s2};
            end
            if (r_cnt != CNT_SAT) begin
              r_cnt <= r_cnt + 7'd1;
            end
          end
        end
        S_LOAD: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_WAIT_IDLE;
        end
      endcase
    end
  end

  // Shadow load and frame-start commit. The commit reads the shadow as it was
  // before this edge, and a same-cycle LOAD wins the pending flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_v0_x <= '0;
      r_sh_v0_y <= '0;
      r_sh_v1_x <= '0;
      r_sh_v1_y <= '0;
      r_sh_v2_x <= '0;
      r_sh_v2_y <= '0;
      v0_x      <= '0;
      v0_y      <= '0;
      v1_x      <= '0;
      v1_y      <= '0;
      v2_x      <= '0;
      v2_y      <= '0;
      pending   <= 1'b0;
      committed <= 1'b0;
    end else begin
      committed <= 1'b0;
      if (frame_start && pending) begin
        v0_x      <= r_sh_v0_x;
        v0_y      <= r_sh_v0_y;
        v1_x      <= r_sh_v1_x;
        v1_y      <= r_sh_v1_y;
        v2_x      <= r_sh_v2_x;
        v2_y      <= r_sh_v2_y;
        committed <= 1'b1;
        pending   <= 1'b0;
      end
      if (w_load) begin
        r_sh_v0_x <= clamp_x(r_shift[56:47]);
        r_sh_v0_y <= clamp_y(r_shift[46:38]);
        r_sh_v1_x <= clamp_x(r_shift[37:28]);
        r_sh_v1_y <= clamp_y(r_shift[27:19]);
        r_sh_v2_x <= clamp_x(r_shift[18:9]);
        r_sh_v2_y <= clamp_y(r_shift[8:0]);
        pending   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_triangle_loader.sv
// Directed bench for triangle_loader: a reference model of the shadow pushes
// each expected commit into a scoreboard, and a monitor pops on `committed`.
module tb_triangle_loader;

  typedef logic [56:0] tri_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_sclk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       frame_start = 1'b0;
  logic [9:0] v0_x, v1_x, v2_x;
  logic [8:0] v0_y, v1_y, v2_y;
  logic       pending, committed, frame_err;

  int   tests = 0;
  int   fails = 0;
  int   commit_cnt = 0;
  int   err_cnt = 0;
  tri_t sb[$];
  tri_t m_shadow = '0;
  tri_t m_active = '0;
  logic m_pending = 1'b0;
  tri_t w_act;

  triangle_loader dut (
    .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .frame_start(frame_start),
    .v0_x(v0_x), .v0_y(v0_y), .v1_x(v1_x), .v1_y(v1_y), .v2_x(v2_x), .v2_y(v2_y),
    .pending(pending), .committed(committed), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  assign w_act = {v0_x, v0_y, v1_x, v1_y, v2_x, v2_y};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic tri_t raw(input int x0, y0, x1, y1, x2, y2);
    return {10'(x0), 9'(y0), 10'(x1), 9'(y1), 10'(x2), 9'(y2)};
  endfunction

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic tri_t clamped(input int x0, y0, x1, y1, x2, y2);
    return raw(mn(x0, 639), mn(y0, 479), mn(x1, 639), mn(y1, 479),
               mn(x2, 639), mn(y2, 479));
  endfunction

  // Commit monitor: every committed pulse must match the oldest expected commit.
  always @(negedge clk) begin : mon
    tri_t e;
    if (rst_n && frame_err) err_cnt++;
    if (rst_n && committed) begin
      commit_cnt++;
      if (sb.size() == 0) begin
        chk("spurious_commit", 64'(w_act), 64'hDEAD);
      end else begin
        e = sb.pop_front();
        chk("commit_value", 64'(w_act), 64'(e));
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clock_bits(input logic [127:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = d[n-1-i];
      wait_clk(3);
      spi_sclk = 1'b1;
      wait_clk(3);
      spi_sclk = 1'b0;
    end
  endtask

  // collide: raise frame_start so it is sampled on the LOAD edge of this frame.
  task automatic send_frame(input logic [127:0] d, input int n, input bit collide);
    spi_cs_n = 1'b0;
    wait_clk(4);
    clock_bits(d, n);
    wait_clk(4);
    spi_cs_n = 1'b1;
    if (collide) begin
      wait_clk(3);
      if (m_pending) begin
        sb.push_back(m_shadow);
        m_active = m_shadow;
      end
      m_pending = 1'b0;
      frame_start = 1'b1;
      wait_clk(1);
      frame_start = 1'b0;
      wait_clk(4);
    end else begin
      wait_clk(8);
    end
  endtask

  task automatic send_tri(input int x0, y0, x1, y1, x2, y2, input bit collide);
    send_frame({64'h0, raw(x0, y0, x1, y1, x2, y2), 7'h5A}, 64, collide);
    m_shadow  = clamped(x0, y0, x1, y1, x2, y2);
    m_pending = 1'b1;
  endtask

  task automatic pulse_fs();
    if (m_pending) begin
      sb.push_back(m_shadow);
      m_active = m_shadow;
    end
    m_pending = 1'b0;
    frame_start = 1'b1;
    wait_clk(1);
    frame_start = 1'b0;
    wait_clk(2);
  endtask

  initial begin : stim
    int c0, e0;
    // reset state
    wait_clk(3);
    chk("rst_outputs", 64'(w_act), 64'h0);
    chk("rst_pending", 64'(pending), 64'h0);
    chk("rst_committed", 64'(committed), 64'h0);
    chk("rst_frame_err", 64'(frame_err), 64'h0);
    rst_n = 1'b1;
    wait_clk(4);

    // basic load and commit
    send_tri(100, 50, 300, 400, 600, 20, 1'b0);
    chk("basic_pending", 64'(pending), 64'(m_pending));
    chk("basic_outputs_held", 64'(w_act), 64'(m_active));
    c0 = commit_cnt;
    pulse_fs();
    chk("basic_commit_count", 64'(commit_cnt - c0), 64'd1);
    chk("basic_outputs", 64'(w_act), 64'(raw(100, 50, 300, 400, 600, 20)));
    chk("basic_pending_clr", 64'(pending), 64'h0);
    c0 = commit_cnt;
    pulse_fs();
    chk("noop_frame_start", 64'(commit_cnt - c0), 64'd0);

    // clamping
    send_tri(1023, 511, 640, 480, 639, 479, 1'b0);
    pulse_fs();
    chk("clamp_outputs", 64'(w_act), 64'(raw(639, 479, 639, 479, 639, 479)));

    // bad lengths leave shadow and pending alone
    send_tri(11, 22, 33, 44, 55, 66, 1'b0);
    e0 = err_cnt;
    send_frame({64'h0, 64'hFFFF_FFFF_FFFF_FFFF}, 63, 1'b0);
    chk("err63_pulse", 64'(err_cnt - e0), 64'd1);
    chk("err63_pending", 64'(pending), 64'd1);
    e0 = err_cnt;
    send_frame({58'h0, 70'h3F_FFFF_FFFF_FFFF_FFFF}, 70, 1'b0);
    chk("err70_pulse", 64'(err_cnt - e0), 64'd1);
    chk("err70_pending", 64'(pending), 64'd1);
    pulse_fs();
    chk("err_shadow_kept", 64'(w_act), 64'(raw(11, 22, 33, 44, 55, 66)));
    e0 = err_cnt;
    send_tri(7, 8, 9, 10, 12, 13, 1'b0);
    chk("after_err_no_err", 64'(err_cnt - e0), 64'd0);
    chk("after_err_pending", 64'(pending), 64'd1);
    pulse_fs();
    chk("after_err_outputs", 64'(w_act), 64'(raw(7, 8, 9, 10, 12, 13)));

    // overwrite before commit
    send_tri(1, 2, 3, 4, 5, 6, 1'b0);
    send_tri(500, 400, 300, 200, 100, 0, 1'b0);
    c0 = commit_cnt;
    pulse_fs();
    chk("overwrite_count", 64'(commit_cnt - c0), 64'd1);
    chk("overwrite_outputs", 64'(w_act), 64'(raw(500, 400, 300, 200, 100, 0)));

    // same-cycle LOAD and frame_start
    send_tri(20, 30, 40, 50, 60, 70, 1'b0);
    c0 = commit_cnt;
    send_tri(620, 470, 610, 460, 600, 450, 1'b1);
    chk("collide_outputs_a", 64'(w_act), 64'(raw(20, 30, 40, 50, 60, 70)));
    chk("collide_count", 64'(commit_cnt - c0), 64'd1);
    chk("collide_pending", 64'(pending), 64'd1);
    pulse_fs();
    chk("collide_outputs_b", 64'(w_act), 64'(raw(620, 470, 610, 460, 600, 450)));

    // reset mid-transaction
    send_tri(200, 100, 210, 110, 220, 120, 1'b0);
    spi_cs_n = 1'b0;
    wait_clk(4);
    clock_bits({64'h0, raw(1, 1, 1, 1, 1, 1), 7'h0}, 20);
    rst_n = 1'b0;
    #2;
    chk("midrst_outputs", 64'(w_act), 64'h0);
    chk("midrst_pending", 64'(pending), 64'h0);
    m_shadow = '0;
    m_active = '0;
    m_pending = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    e0 = err_cnt;
    clock_bits({64'h0, raw(99, 98, 97, 96, 95, 94), 7'h0}, 64);
    wait_clk(4);
    spi_cs_n = 1'b1;
    wait_clk(8);
    chk("postrst_no_capture", 64'(pending), 64'h0);
    chk("postrst_no_err", 64'(err_cnt - e0), 64'd0);
    c0 = commit_cnt;
    pulse_fs();
    chk("postrst_no_commit", 64'(commit_cnt - c0), 64'd0);
    chk("postrst_outputs", 64'(w_act), 64'h0);
    send_tri(321, 123, 432, 234, 543, 345, 1'b0);
    pulse_fs();
    chk("postrst_load", 64'(w_act), 64'(raw(321, 123, 432, 234, 543, 345)));

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/triangle_loader.md
# triangle_loader

Upstream feeder for `tt_um_emern_raster_core`. It receives one triangle (three vertices) per SPI transaction from the host and range-clamps it into a shadow register. The shadow is committed to the vertex outputs only on the frame-start pulse, so the raster core never sees a triangle change partway through a frame. Its outputs drive `v0_x..v2_y` of the raster core directly.

## Interface

Parameters:
- `X_MAX`, default 639: largest legal column; loaded x values above it are clamped to it.
- `Y_MAX`, default 479: largest legal row; loaded y values above it are clamped to it.

Ports:
- `clk`  in  1  system (pixel) clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `spi_sclk`  in  1  SPI clock, mode 0, asynchronous to `clk`.
- `spi_cs_n`  in  1  SPI chip select, active low, asynchronous.
- `spi_mosi`  in  1  SPI data, MSB first, asynchronous.
- `frame_start`  in  1  one-`clk` pulse from the timing generator at the start of vertical blanking.
- `v0_x`, `v1_x`, `v2_x`  out  10 each  active vertex columns.
- `v0_y`, `v1_y`, `v2_y`  out  9 each  active vertex rows.
- `pending`  out  1  shadow holds a valid triangle that has not been committed.
- `committed`  out  1  one-cycle pulse when the active vertices update.
- `frame_err`  out  1  one-cycle pulse when a transaction is discarded for a bad length.

## Operation

- **Input synchronisers:** `spi_sclk`, `spi_cs_n` and `spi_mosi` each pass through 2-flop synchronisers.
  - The sclk rising edge and the cs_n falling and rising edges are detected on the synchronised signals.
- **Frame format:** exactly 64 bits, MSB first.
  - [63:54] v0_x, [53:45] v0_y, [44:35] v1_x, [34:26] v1_y, [25:16] v2_x, [15:7] v2_y.
  - [6:0] are reserved and ignored.
- **FSM states:**
  - WAIT_IDLE is the state after reset. Stay until synchronised cs_n is high, then go to IDLE. This prevents a partial transaction from being captured after reset.
  - IDLE: on a cs_n falling edge, clear the bit counter and the shift register, then go to SHIFT.
  - SHIFT: on each sclk rising edge, shift the synchronised mosi into the LSB and increment the 7-bit counter. The counter saturates at 65.
  - On a cs_n rising edge in SHIFT:
    - If count == 64, go to LOAD.
    - Otherwise, pulse `frame_err` and go to IDLE. The shadow and `pending` are left unchanged.
  - LOAD: lasts one cycle. Clamp each field and write all six fields to the shadow. Set `pending` = 1 (overwriting any uncommitted shadow). Go to IDLE.
- **Clamping:** apply x = min(x, X_MAX) and y = min(y, Y_MAX) as unsigned comparisons on the full field width.
- **Commit:** when `frame_start` = 1 and `pending` = 1:
  - Copy the shadow to the v outputs.
  - Clear `pending`.
  - Pulse `committed`.
  - If `pending` = 0, `frame_start` is a no-op.
- **Simultaneous LOAD and frame_start in the same cycle:**
  - The commit uses the shadow value from before the LOAD. It commits only if `pending` was already 1.
  - The newly loaded triangle then remains in the shadow with `pending` = 1 and commits at the next `frame_start`.
- **Reset values:**
  - All v outputs are 0; the shadow is 0.
  - `pending`, `committed` and `frame_err` are 0.
  - The FSM is in WAIT_IDLE.
- **Reset mid-transaction:** the partial transaction is abandoned. The next capture requires a fresh cs_n high→low sequence.

## Timing

- The `spi_sclk` period must be at least 4 `clk` periods, with high and low phases of at least 2 `clk` each.
- `spi_cs_n` setup to the first sclk edge, and hold after the last sclk edge, must each be at least 3 `clk`.
- Edge detection latency is 3 `clk` cycles from the input pin to the detected edge (2 synchroniser stages plus the edge register).
- The cycle in which the cs_n rising edge is detected is cycle N:
  - LOAD occurs in N+1.
  - The shadow is valid and `pending` = 1 from N+2.
- `frame_err` is high for exactly cycle N+1.
- If `frame_start` is high at clock edge M (with `pending` = 1):
  - The v outputs carry the new values from cycle M+1.
  - `committed` is high for cycle M+1 only.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan

- **Reset:** assert `rst_n` = 0 asynchronously mid-SPI frame. Required: all outputs become 0 immediately. After release, holding cs_n low and clocking 64 bits captures nothing (`pending` stays 0).
- **Basic load and commit:** send v0=(100,50), v1=(300,400), v2=(600,20). Required: `pending` = 1 and the outputs are still 0. After a `frame_start` pulse, the outputs equal the sent values and `committed` pulses once.
- **Clamping:** send v0_x = 1023, v0_y = 511, v1 = (640,480), v2 = (639,479). After commit, required: v0 = (639,479), v1 = (639,479), v2 = (639,479).
- **Bad length:** send a 63-bit frame, then a 70-bit frame. Required: `frame_err` pulses after each, and `pending` and the shadow are unchanged. A following correct 64-bit frame loads normally.
- **Overwrite before commit:** send triangle A, then triangle B, before any `frame_start`. Required: a single commit produces B.
- **Same-cycle collision:** start with triangle A pending. Align B's LOAD cycle with a `frame_start` pulse. Required: the outputs show A and `pending` stays 1. The next `frame_start` shows B.
